// File: rtl/mem_pkg.sv
// Shared types for the LoongArch MEM stage: bus layouts, access sizes and FSM state encoding.
package mem_pkg;

    localparam int ES_TO_MS_W = 108;
    localparam int MS_TO_WS_W = 70;
    localparam int MS_FWD_W   = 39;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef logic [1:0] ms_state_t;
    localparam ms_state_t ST_IDLE = 2'd0;
    localparam ms_state_t ST_REQ  = 2'd1;
    localparam ms_state_t ST_WAIT = 2'd2;
    localparam ms_state_t ST_DONE = 2'd3;

    // Field order is the bit layout of each bus, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] rkd_value;
        logic        mem_en;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        res_from_mem;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } ms_to_ws_t;

    typedef struct packed {
        logic        busy;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } ms_fwd_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == MEM_SIZE_H) && a[0]) || ((size == MEM_SIZE_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data SRAM request/response bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_sram_req;
    logic              data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [3:0]        data_sram_wstrb;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed byte/half down and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            MEM_SIZE_B: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_H: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:    data = shifted;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// LoongArch MEM stage: drives the data SRAM, aligns load data, hands results to WB and forwards to ID.
// Define MEM_ALE_EN to trap misaligned half/word accesses (no request issued, ms_ale raised).
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            es_to_ms_valid,
    output logic            ms_allowin,
    input  es_to_ms_t       es_to_ms_bus,
    mem_stage_if.master     sram,
    output logic            ms_to_ws_valid,
    input  logic            ws_allowin,
    output ms_to_ws_t       ms_to_ws_bus,
    output ms_fwd_t         ms_fwd_bus
`ifdef MEM_ALE_EN
    ,
    output logic            ms_ale
`endif
);
    ms_state_t   state;
    logic        ms_valid;
    es_to_ms_t   es_r;
    logic [31:0] rdata_buf;
    logic        ms_ready_go;
    logic        accept;
    logic        ale_in;
    logic        ale;
    logic [1:0]  a;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        rf_we_out;
    logic [31:0] rf_wdata;

`ifdef MEM_ALE_EN
    assign ale_in = es_to_ms_bus.mem_en & is_misaligned(es_to_ms_bus.mem_size, es_to_ms_bus.alu_result[1:0]);
    assign ale    = ms_valid & es_r.mem_en & is_misaligned(es_r.mem_size, es_r.alu_result[1:0]);
    assign ms_ale = ale;
`else
    assign ale_in = 1'b0;
    assign ale    = 1'b0;
`endif

    assign ms_ready_go    = (state == ST_IDLE) || (state == ST_DONE);
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept         = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ms_valid  <= 1'b0;
            es_r      <= '0;
            rdata_buf <= '0;
        end else begin
            if (accept) begin
                ms_valid <= 1'b1;
                es_r     <= es_to_ms_bus;
            end else if (ms_to_ws_valid && ws_allowin) begin
                ms_valid <= 1'b0;
            end

            if (accept) begin
                state <= ale_in ? ST_DONE : (es_to_ms_bus.mem_en ? ST_REQ : ST_IDLE);
            end else begin
                // Responses seen outside WAIT belong to a request killed by reset and are dropped.
                case (state)
                    ST_REQ:  if (sram.data_sram_addr_ok) state <= ST_WAIT;
                    ST_WAIT: if (sram.data_sram_data_ok) begin
                        state     <= ST_DONE;
                        rdata_buf <= sram.data_sram_rdata;
                    end
                    ST_DONE: if (ws_allowin) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign a = es_r.alu_result[1:0];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        wdata = es_r.rkd_value;
        wstrb = 4'b1111;
        case (es_r.mem_size)
            MEM_SIZE_B: begin
                wdata = {4{es_r.rkd_value[7:0]}};
                wstrb = 4'b0001 << a;
            end
            MEM_SIZE_H: begin
                wdata = {2{es_r.rkd_value[15:0]}};
                wstrb = 4'b0011 << {a[1], 1'b0};
            end
            default: ;
        endcase
        if (!es_r.mem_wr) wstrb = 4'b0000;
    end

    assign sram.data_sram_req   = ms_valid && es_r.mem_en && (state == ST_REQ);
    assign sram.data_sram_wr    = es_r.mem_wr;
    assign sram.data_sram_size  = es_r.mem_size;
    assign sram.data_sram_wstrb = wstrb;
    assign sram.data_sram_addr  = ADDR_W'(es_r.alu_result);
    assign sram.data_sram_wdata = DATA_W'(wdata);

    mem_load_align u_load_align (
        .rdata       (rdata_buf),
        .addr_lo     (a),
        .size        (es_r.mem_size),
        .is_unsigned (es_r.mem_unsigned),
        .data        (load_data)
    );

    // A trapped access reports its faulting address in rf_wdata and never writes the RF.
    assign rf_we_out = es_r.rf_we && !ale;
    assign rf_wdata  = (es_r.res_from_mem && !ale) ? load_data : es_r.alu_result;

    assign ms_to_ws_bus.pc       = es_r.pc;
    assign ms_to_ws_bus.rf_we    = rf_we_out;
    assign ms_to_ws_bus.rf_waddr = es_r.rf_waddr;
    assign ms_to_ws_bus.rf_wdata = rf_wdata;

    assign ms_fwd_bus.busy     = ms_valid && es_r.res_from_mem && (state != ST_DONE);
    assign ms_fwd_bus.rf_we    = ms_valid && rf_we_out;
    assign ms_fwd_bus.rf_waddr = es_r.rf_waddr;
    assign ms_fwd_bus.rf_wdata = rf_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores/ALU ops, SRAM stalls, WB back-pressure, reset mid-access.
module tb_mem_stage;
    import mem_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      es_to_ms_valid = 1'b0;
    es_to_ms_t es_to_ms_bus = '0;
    logic      ms_allowin;
    logic      ms_to_ws_valid;
    logic      ws_allowin = 1'b1;
    ms_to_ws_t ms_to_ws_bus;
    ms_fwd_t   ms_fwd_bus;
`ifdef MEM_ALE_EN
    logic      ms_ale;
`endif

    always #5 clk = ~clk;

    mem_stage_if sram ();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .es_to_ms_valid (es_to_ms_valid),
        .ms_allowin     (ms_allowin),
        .es_to_ms_bus   (es_to_ms_bus),
        .sram           (sram),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_fwd_bus     (ms_fwd_bus)
`ifdef MEM_ALE_EN
        ,
        .ms_ale         (ms_ale)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    ms_to_ws_t wb_q[$];
    req_t      req_q[$];
    int          aok_stall = 0;
    int          dok_stall = 0;
    logic [31:0] rdata_next = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic es_to_ms_t mk_es(input logic [31:0] p, input logic [31:0] alu, input logic [31:0] rkd,
                                        input logic en, input logic wr, input logic [1:0] sz, input logic uns,
                                        input logic we, input logic [4:0] wa, input logic rfm);
        es_to_ms_t e;
        e.pc = p; e.alu_result = alu; e.rkd_value = rkd;
        e.mem_en = en; e.mem_wr = wr; e.mem_size = sz; e.mem_unsigned = uns;
        e.rf_we = we; e.rf_waddr = wa; e.res_from_mem = rfm;
        return e;
    endfunction

    function automatic ms_to_ws_t mk_wb(input logic [31:0] p, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ms_to_ws_t w;
        w.pc = p; w.rf_we = we; w.rf_waddr = wa; w.rf_wdata = wd;
        return w;
    endfunction

    function automatic req_t mk_req(input logic wr, input logic [1:0] sz, input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd);
        req_t r;
        r.wr = wr; r.size = sz; r.wstrb = st; r.addr = ad; r.wdata = wd;
        return r;
    endfunction

    // Data SRAM model: addr_ok after aok_stall cycles of req, data_ok dok_stall cycles after that.
    initial begin : sram_slave
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        sram.data_sram_addr_ok = 1'b0;
        sram.data_sram_data_ok = 1'b0;
        sram.data_sram_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            sram.data_sram_addr_ok = 1'b0;
            sram.data_sram_data_ok = 1'b0;
            if (phase == 0 && sram.data_sram_req) begin
                phase = 1;
                cnt   = aok_stall;
            end
            if (phase == 1) begin
                if (cnt == 0) begin
                    sram.data_sram_addr_ok = 1'b1;
                    phase = 2;
                    cnt   = dok_stall;
                end else cnt--;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    sram.data_sram_data_ok = 1'b1;
                    sram.data_sram_rdata   = rdata_next;
                    phase = 0;
                end else cnt--;
            end
        end
    end

    // Monitor: compares every presented SRAM request and every WB transfer against the queues.
    always @(negedge clk) begin
        if (!rst && sram.data_sram_req) begin
            if (req_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL req_unexpected: got addr 0x%0h, want no request", sram.data_sram_addr);
            end else begin
                req_t act;
                act = mk_req(sram.data_sram_wr, sram.data_sram_size, sram.data_sram_wstrb,
                             sram.data_sram_addr, sram.data_sram_wdata);
                check("req_fields", act, req_q[0]);
                if (sram.data_sram_addr_ok) void'(req_q.pop_front());
            end
        end
        if (!rst && ms_to_ws_valid && ws_allowin) begin
            if (wb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL wb_unexpected: got pc 0x%0h, want no transfer", ms_to_ws_bus.pc);
            end else begin
                check("wb_bus", ms_to_ws_bus, wb_q.pop_front());
            end
        end
    end

    task automatic send(input es_to_ms_t b, output int waits);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!ms_allowin && waits < 50);
        if (!ms_allowin) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got ms_allowin 0, want 1");
        end
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    // Returns at the first negedge where ms_to_ws_valid is high; n counts negedges waited.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ms_to_ws_valid && n < 50);
        if (!ms_to_ws_valid) begin
            n_cmp++; n_err++;
            $display("FAIL out_timeout: got ms_to_ws_valid 0, want 1");
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int w;
        int n;
        ms_fwd_t   exp_fwd;
        ms_to_ws_t exp_wb;

        repeat (3) @(negedge clk);
        check("rst_req", sram.data_sram_req, 1'b0);
        check("rst_ws_valid", ms_to_ws_valid, 1'b0);
        check("rst_fwd", ms_fwd_bus, '0);
        check("rst_ws_bus", ms_to_ws_bus, '0);
        check("rst_allowin", ms_allowin, 1'b1);
        next_cycle();
        rst = 1'b0;

        // ALU op: result one cycle after accept, no SRAM traffic.
        wb_q.push_back(mk_wb(32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678));
        send(mk_es(32'h1C00_0000, 32'h1234_5678, 32'h0, 1'b0, 1'b0, MEM_SIZE_W, 1'b0, 1'b1, 5'd5, 1'b0), w);
        wait_out(n);
        check("alu_latency", n, 1);
        exp_fwd = '{busy: 1'b0, rf_we: 1'b1, rf_waddr: 5'd5, rf_wdata: 32'h1234_5678};
        check("alu_fwd", ms_fwd_bus, exp_fwd);
        next_cycle();

        // ld.b signed from byte 3.
        rdata_next = 32'h80FF_FFFF;
        req_q.push_back(mk_req(1'b0, MEM_SIZE_B, 4'b0000, 32'h1C00_0003, 32'h4444_4444));
        wb_q.push_back(mk_wb(32'h1C00_0004, 1'b1, 5'd7, 32'hFFFF_FF80));
        send(mk_es(32'h1C00_0004, 32'h1C00_0003, 32'h1122_3344, 1'b1, 1'b0, MEM_SIZE_B, 1'b0, 1'b1, 5'd7, 1'b1), w);
        @(negedge clk);
        check("ldb_fwd_busy", ms_fwd_bus[38:32], 7'b1100111);
        wait_out(n);
        check("ldb_latency", n, 2);
        exp_fwd = '{busy: 1'b0, rf_we: 1'b1, rf_waddr: 5'd7, rf_wdata: 32'hFFFF_FF80};
        check("ldb_fwd_done", ms_fwd_bus, exp_fwd);
        next_cycle();

        // ld.bu from byte 3.
        req_q.push_back(mk_req(1'b0, MEM_SIZE_B, 4'b0000, 32'h1C00_0003, 32'h4444_4444));
        wb_q.push_back(mk_wb(32'h1C00_0008, 1'b1, 5'd7, 32'h0000_0080));
        send(mk_es(32'h1C00_0008, 32'h1C00_0003, 32'h1122_3344, 1'b1, 1'b0, MEM_SIZE_B, 1'b1, 1'b1, 5'd7, 1'b1), w);
        wait_out(n);
        next_cycle();

        // st.h to offset 2 with addr_ok held off for 3 cycles.
        aok_stall = 3;
        req_q.push_back(mk_req(1'b1, MEM_SIZE_H, 4'b1100, 32'h1C00_0012, 32'h1234_1234));
        wb_q.push_back(mk_wb(32'h1C00_000C, 1'b0, 5'd0, 32'h1C00_0012));
        send(mk_es(32'h1C00_000C, 32'h1C00_0012, 32'hABCD_1234, 1'b1, 1'b1, MEM_SIZE_H, 1'b0, 1'b0, 5'd0, 1'b0), w);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (sram.data_sram_req) n++;
            if (sram.data_sram_req && sram.data_sram_addr_ok) break;
        end
        check("sth_req_cycles", n, 4);
        aok_stall = 0;
        wait_out(n);
        next_cycle();

        // ld.w held in DONE by WB for 4 cycles, then release and accept ld.h in the same cycle.
        ws_allowin = 1'b0;
        rdata_next = 32'hDEAD_BEEF;
        exp_wb = mk_wb(32'h1C00_0010, 1'b1, 5'd3, 32'hDEAD_BEEF);
        req_q.push_back(mk_req(1'b0, MEM_SIZE_W, 4'b0000, 32'h1C00_0020, 32'h5566_7788));
        wb_q.push_back(exp_wb);
        send(mk_es(32'h1C00_0010, 32'h1C00_0020, 32'h5566_7788, 1'b1, 1'b0, MEM_SIZE_W, 1'b0, 1'b1, 5'd3, 1'b1), w);
        wait_out(n);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_allowin", ms_allowin, 1'b0);
            check("stall_valid", ms_to_ws_valid, 1'b1);
            check("stall_bus", ms_to_ws_bus, exp_wb);
        end
        next_cycle();
        ws_allowin = 1'b1;
        rdata_next = 32'h8001_7FFE;
        req_q.push_back(mk_req(1'b0, MEM_SIZE_H, 4'b0000, 32'h1C00_0022, 32'h0000_0000));
        wb_q.push_back(mk_wb(32'h1C00_0014, 1'b1, 5'd4, 32'hFFFF_8001));
        send(mk_es(32'h1C00_0014, 32'h1C00_0022, 32'h0, 1'b1, 1'b0, MEM_SIZE_H, 1'b0, 1'b1, 5'd4, 1'b1), w);
        check("release_accept_wait", w, 1);
        @(negedge clk);
        check("no_bubble_req", sram.data_sram_req, 1'b1);
        wait_out(n);
        next_cycle();

        // Reset while waiting for data; the late data_ok must be dropped.
        dok_stall = 1;
        req_q.push_back(mk_req(1'b0, MEM_SIZE_W, 4'b0000, 32'h1C00_0030, 32'h0000_0000));
        send(mk_es(32'h1C00_0018, 32'h1C00_0030, 32'h0, 1'b1, 1'b0, MEM_SIZE_W, 1'b0, 1'b1, 5'd6, 1'b1), w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sram.data_sram_req && sram.data_sram_addr_ok) && n < 20);
        check("rstw_addr_ok_seen", sram.data_sram_req && sram.data_sram_addr_ok, 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        dok_stall = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_ws_valid", ms_to_ws_valid, 1'b0);
            check("rstw_req", sram.data_sram_req, 1'b0);
            check("rstw_allowin", ms_allowin, 1'b1);
            check("rstw_fwd", ms_fwd_bus, '0);
        end
        next_cycle();

        // Normal operation resumes after the mid-access reset.
        wb_q.push_back(mk_wb(32'h1C00_001C, 1'b1, 5'd8, 32'hCAFE_F00D));
        send(mk_es(32'h1C00_001C, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, MEM_SIZE_W, 1'b0, 1'b1, 5'd8, 1'b0), w);
        wait_out(n);
        check("post_rst_latency", n, 1);
        next_cycle();

`ifdef MEM_ALE_EN
        // Misaligned ld.w: no request, trap flagged, RF write suppressed.
        wb_q.push_back(mk_wb(32'h1C00_0024, 1'b0, 5'd9, 32'h1C00_0042));
        send(mk_es(32'h1C00_0024, 32'h1C00_0042, 32'h0, 1'b1, 1'b0, MEM_SIZE_W, 1'b0, 1'b1, 5'd9, 1'b1), w);
        wait_out(n);
        check("ale_latency", n, 1);
        check("ale_flag", ms_ale, 1'b1);
        check("ale_no_req", sram.data_sram_req, 1'b0);
        next_cycle();
`endif

        repeat (4) next_cycle();
        check("wb_q_drained", wb_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
